idct1d_butterfly: RTL and testbench
===================================

Name: idct1d_butterfly

Overview:
- Inverse of the 1-D DCT first-stage butterfly: rebuilds the eight n-bit samples x[0..7] from four (sum, difference) pairs.
- Coefficients are written by address. Reconstruction runs one pair per cycle on a single add/subtract pair.
- Results are streamed out serially under oe.
- Sits on the decode path after the later inverse DCT stages, feeding the pixel write-back.

Parameters:
- n, 8, output sample width. Input words are n+1 bits signed.

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- wr  input  1  write data_in to coefficient memory at add.
- start  input  1  begin reconstruction (accepted only in IDLE).
- oe  input  1  output enable; advances the read stream.
- data_in  input  n+1  signed coefficient word.
- add  input  3  coefficient address.
- busy  output  1  high in COMPUTE and READ.
- done  output  1  high in DONE.
- valid_out  output  1  data_out carries a valid sample this cycle.
- data_out  output  n  reconstructed sample, natural order x[0]..x[7].
- err  output  1  sticky odd-pair flag (see Optional Feature).

Behaviour:
- Clock and reset: one clock domain, clk. reset is asynchronous, active-high. On reset, all of the following are cleared:
  - memory c[0..7]=0 and result regs y[0..7]=0
  - state=IDLE, pair counter p=0, read index k=0
  - busy=0, done=0, valid_out=0, data_out=0, err=0
  - Reset during any state aborts the operation immediately. No partial output follows.
- Memory: c[add] <= data_in on a clk edge with wr=1, only when state is IDLE or DONE.
  - Writes in COMPUTE or READ are ignored.
  - A write in DONE leaves y intact.
- Pair map: pair p uses sum s=c[2p] and diff d=c[2p+1]. Output indices (a,b) per pair:
  - p0 -> (0,7)
  - p1 -> (4,1)
  - p2 -> (6,2)
  - p3 -> (5,3)
- Arithmetic:
  - t+ = s+d and t- = s-d, both n+2 bits signed.
  - y[a] = (t+ >>> 1) truncated to the low n bits; y[b] = (t- >>> 1) truncated to the low n bits.
  - No saturation.
- FSM:
  - IDLE: start=1 -> COMPUTE with p=0. wr and start on the same edge: the write commits first and COMPUTE sees the new value.
  - COMPUTE: each cycle writes y for pair p and increments p. After p=3 -> DONE. Lasts exactly 4 cycles; start is ignored.
  - DONE: done=1. oe=1 -> READ with k=0. start=1 with oe=0 -> COMPUTE again, recomputing from current memory. If start and oe are both high, oe wins.
  - READ: on each edge with oe=1, data_out <= y[k], valid_out <= 1, k increments. On an edge with oe=0, valid_out <= 0 and data_out holds (pause). After k=7 is emitted -> IDLE, with valid_out dropping on the next edge.
- Latency:
  - start accepted at edge E0; done=1 after edge E4.
  - oe high continuously from DONE gives 8 back-to-back valid samples, the first one edge after entering READ.

Optional Feature:
- Macro: IDCT_PAIR_CHECK_EN
- Defined: err sets sticky when the LSB of t+ is 1 for any pair in COMPUTE, meaning an inconsistent pair that a forward butterfly cannot produce. err is cleared by reset or by the next accepted start.
- Undefined: err is tied to 0 and the check logic is not synthesized.
- Datapath results are identical either way.

Test Plan:
- Natural order: write c0..c7 = 90,-70,70,30,100,40,100,20, start, then hold oe -> done after 4 compute cycles; stream 10,20,30,40,50,60,70,80 with valid_out high for 8 consecutive cycles; err=0.
- Extremes (n=8): c0=255, c1=255, others 0 -> x0=255, x7=0, all other samples 0.
- Pause: same data as the natural-order test, oe toggled 1,0,1,1,0,... -> valid_out low and data_out held during gaps; the sequence is still 10..80 with no loss or duplication.
- Busy lockout: wr to add=0 with data 0 during COMPUTE, and a start pulse in READ -> stream unchanged, FSM returns to IDLE after 8 samples.
- Reset mid-op: assert reset asynchronously at READ sample 3 -> all outputs 0 at once; after release, a read with no start gives no valid_out; start then a read streams all zeros.
- Pair check (macro defined): c0=3, c1=0 -> err=1 after COMPUTE and stays set until the next start. With the macro undefined, err=0.

Source files
------------

// File: rtl/idct1d_butterfly.sv
// idct1d_butterfly
//
// Inverse of the first-stage 1-D DCT butterfly. Eight signed (n+1)-bit
// coefficients are written by address into a small memory as four
// (sum, difference) pairs. A start pulse reconstructs the eight n-bit
// samples, one pair per cycle, on a single add/subtract pair. The samples
// are then streamed out in natural order x[0]..x[7] under oe.
//
// State table:
//   IDLE    | waiting; coefficient writes allowed, start accepted
//   COMPUTE | one pair per cycle into the result regs, 4 cycles
//   DONE    | results ready; writes allowed, oe begins read, start recomputes
//   READ    | one sample per oe-high edge, back to IDLE after x[7]
//
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous, active-high reset
//   wr         write data_in to coefficient memory at add (IDLE/DONE only)
//   start      begin reconstruction (IDLE, or DONE with oe low)
//   oe         output enable, advances the read stream
//   data_in    signed (n+1)-bit coefficient word
//   add        coefficient address
//   busy       high in COMPUTE and READ
//   done       high in DONE
//   valid_out  data_out carries a valid sample this cycle
//   data_out   reconstructed n-bit sample
//   err        sticky odd-pair flag
//
// Optional feature: define IDCT_PAIR_CHECK_EN to build the pair consistency
// check. When undefined err is tied low and no check logic exists.

module idct1d_butterfly #(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr,
    input  logic         start,
    input  logic         oe,
    input  logic [n:0]   data_in,
    input  logic [2:0]   add,
    output logic         busy,
    output logic         done,
    output logic         valid_out,
    output logic [n-1:0] data_out,
    output logic         err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2,
        READ    = 2'd3
    } state_t;

    state_t state, state_next;

    logic signed [n:0]   c_mem [0:7];
    logic [n-1:0]        y_reg [0:7];
    logic [1:0]          p;
    logic [2:0]          k;
    logic                start_accept;

    logic signed [n:0]   s_word;
    logic signed [n:0]   d_word;
    logic signed [n+1:0] t_plus;
    logic signed [n+1:0] t_minus;
    logic [2:0]          idx_a;
    logic [2:0]          idx_b;
    logic                unused_bits;

    // Next-state logic; oe takes priority over start in DONE.
    always_comb begin
        state_next   = state;
        start_accept = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next   = COMPUTE;
                    start_accept = 1'b1;
                end
            end
            COMPUTE: begin
                if (p == 2'd3) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (oe) begin
                    state_next = READ;
                end else if (start) begin
                    state_next   = COMPUTE;
                    start_accept = 1'b1;
                end
            end
            READ: begin
                if (oe && (k == 3'd7)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output slots for each pair: (a, b) receive the sum and difference halves.
    always_comb begin
        idx_a = 3'd0;
        idx_b = 3'd7;
        case (p)
            2'd0: begin idx_a = 3'd0; idx_b = 3'd7; end
            2'd1: begin idx_a = 3'd4; idx_b = 3'd1; end
            2'd2: begin idx_a = 3'd6; idx_b = 3'd2; end
            2'd3: begin idx_a = 3'd5; idx_b = 3'd3; end
            default: begin idx_a = 3'd0; idx_b = 3'd7; end
        endcase
    end

    assign s_word  = c_mem[{p, 1'b0}];
    assign d_word  = c_mem[{p, 1'b1}];
    assign t_plus  = {s_word[n], s_word} + {d_word[n], d_word};
    assign t_minus = {s_word[n], s_word} - {d_word[n], d_word};

    // An arithmetic shift right by one followed by truncation to n bits is
    // simply bits [n:1]; the top bit and the LSB are dropped.
    assign unused_bits = ^{t_plus[n+1], t_plus[0], t_minus[n+1], t_minus[0]};

    assign busy = (state == COMPUTE) || (state == READ);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            p         <= 2'd0;
            k         <= 3'd0;
            valid_out <= 1'b0;
            data_out  <= '0;
            for (int i = 0; i < 8; i++) begin
                c_mem[i] <= '0;
                y_reg[i] <= '0;
            end
        end else begin
            state     <= state_next;
            valid_out <= 1'b0;

            if (wr && ((state == IDLE) || (state == DONE))) begin
                c_mem[add] <= data_in;
            end

            if (start_accept) begin
                p <= 2'd0;
            end

            case (state)
                COMPUTE: begin
                    y_reg[idx_a] <= t_plus[n:1];
                    y_reg[idx_b] <= t_minus[n:1];
                    p            <= p + 2'd1;
                end
                DONE: begin
                    if (oe) begin
                        k <= 3'd0;
                    end
                end
                READ: begin
                    if (oe) begin
                        data_out  <= y_reg[k];
                        valid_out <= 1'b1;
                        k         <= k + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef IDCT_PAIR_CHECK_EN
    // A forward butterfly always yields an even s+d; an odd one flags a
    // corrupted pair. Cleared by the next accepted start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else if (start_accept) begin
            err <= 1'b0;
        end else if ((state == COMPUTE) && t_plus[0]) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_idct1d_butterfly.sv
module tb_idct1d_butterfly;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         wr;
    logic         start;
    logic         oe;
    logic [N:0]   data_in;
    logic [2:0]   add;
    logic         busy;
    logic         done;
    logic         valid_out;
    logic [N-1:0] data_out;
    logic         err;

    int checks = 0;
    int errors = 0;
    int mem [8];
    int exp_q [$];
    int exp_err = 0;

    always #5 clk = ~clk;

    idct1d_butterfly #(.n(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr        (wr),
        .start     (start),
        .oe        (oe),
        .data_in   (data_in),
        .add       (add),
        .busy      (busy),
        .done      (done),
        .valid_out (valid_out),
        .data_out  (data_out),
        .err       (err)
    );

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_mem(input int a, input int v);
        wr      = 1'b1;
        add     = a[2:0];
        data_in = v[N:0];
        tick();
        wr      = 1'b0;
        mem[a]  = v;
    endtask

    // Reference reconstruction from the bench's copy of the memory.
    function automatic void model_push();
        int ia [4] = '{0, 4, 6, 5};
        int ib [4] = '{7, 1, 2, 3};
        int y [8];
        int tp, tm;
        bit odd = 1'b0;
        for (int q = 0; q < 4; q++) begin
            tp = mem[2*q] + mem[2*q+1];
            tm = mem[2*q] - mem[2*q+1];
            y[ia[q]] = (tp >>> 1) & ((1 << N) - 1);
            y[ib[q]] = (tm >>> 1) & ((1 << N) - 1);
            if ((tp & 1) != 0) odd = 1'b1;
        end
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(y[i]);
`ifdef IDCT_PAIR_CHECK_EN
        exp_err = odd ? 1 : 0;
`else
        exp_err = 0;
`endif
    endfunction

    // Accept start, optionally with a write on the same edge and/or a
    // locked-out write during COMPUTE; checks done appears exactly after E4.
    task automatic start_compute(input bit lock_wr, input bit with_wr, input int wa, input int wv);
        if (with_wr) begin
            wr      = 1'b1;
            add     = wa[2:0];
            data_in = wv[N:0];
            mem[wa] = wv;
        end
        model_push();
        start = 1'b1;
        tick();
        start = 1'b0;
        wr    = 1'b0;
        check_val("busy_after_start", busy, 1);
        check_val("err_clear_on_start", err, 0);
        if (lock_wr) begin
            wr      = 1'b1;
            add     = 3'd0;
            data_in = '0;
            tick();
            wr = 1'b0;
            repeat (2) tick();
        end else begin
            repeat (3) tick();
        end
        check_val("done_before_e4", done, 0);
        tick();
        check_val("done_at_e4", done, 1);
        check_val("busy_in_done", busy, 0);
        check_val("err_after_compute", err, exp_err);
    endtask

    // Drive oe from DONE and compare the stream against the scoreboard.
    task automatic read_stream(input bit pause, input bit start_at_done,
                               input bit start_in_read, input int stop_after);
        int  got = 0;
        int  cyc = 0;
        int  last = 0;
        bit  in_read = 1'b0;
        bit  oe_val;
        bit  exp_v;
        int  exp_d;
        while (got < stop_after && cyc < 100) begin
            oe_val = pause ? !((cyc % 5 == 1) || (cyc % 5 == 4)) : 1'b1;
            oe     = oe_val;
            start  = (start_at_done && cyc == 0) || (start_in_read && cyc == 3);
            exp_v  = in_read && oe_val;
            tick();
            start = 1'b0;
            check_val("valid_out", valid_out, exp_v);
            if (valid_out) begin
                if (exp_q.size() == 0) begin
                    check_val("sb_underflow", 1, 0);
                end else begin
                    exp_d = exp_q.pop_front();
                    check_val("data_out", data_out, exp_d);
                end
                last = data_out;
            end else if (got > 0) begin
                check_val("data_hold", data_out, last);
            end
            if (!in_read && oe_val) in_read = 1'b1;
            else if (exp_v) got++;
            cyc++;
        end
        if (got < stop_after) check_val("read_budget", got, stop_after);
        if (stop_after == 8) begin
            oe = 1'b0;
            tick();
            check_val("valid_after_read", valid_out, 0);
            check_val("busy_after_read", busy, 0);
            check_val("done_after_read", done, 0);
            check_val("sb_empty", exp_q.size(), 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nat [8] = '{90, -70, 70, 30, 100, 40, 100, 20};
        reset   = 1'b1;
        wr      = 1'b0;
        start   = 1'b0;
        oe      = 1'b0;
        data_in = '0;
        add     = '0;
        for (int i = 0; i < 8; i++) mem[i] = 0;
        repeat (2) tick();
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_valid", valid_out, 0);
        check_val("rst_data", data_out, 0);
        check_val("rst_err", err, 0);
        reset = 1'b0;
        tick();

        // Natural order, with start and oe together in DONE (oe wins).
        for (int i = 0; i < 8; i++) write_mem(i, nat[i]);
        start_compute(1'b0, 1'b0, 0, 0);
        read_stream(1'b0, 1'b1, 1'b0, 8);

        // Pause pattern on the same data.
        start_compute(1'b0, 1'b0, 0, 0);
        read_stream(1'b1, 1'b0, 1'b0, 8);

        // Busy lockout: write during COMPUTE, start during READ.
        start_compute(1'b1, 1'b0, 0, 0);
        read_stream(1'b0, 1'b0, 1'b1, 8);

        // Reset asynchronously after the third sample.
        start_compute(1'b0, 1'b0, 0, 0);
        read_stream(1'b0, 1'b0, 1'b0, 3);
        #3 reset = 1'b1;
        #1;
        check_val("async_rst_valid", valid_out, 0);
        check_val("async_rst_data", data_out, 0);
        check_val("async_rst_busy", busy, 0);
        check_val("async_rst_done", done, 0);
        check_val("async_rst_err", err, 0);
        tick();
        reset = 1'b0;
        oe    = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 8; i++) mem[i] = 0;
        tick();
        oe = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_val("no_start_valid", valid_out, 0);
        end
        oe = 1'b0;
        tick();
        start_compute(1'b0, 1'b0, 0, 0);
        read_stream(1'b0, 1'b0, 1'b0, 8);

        // Extremes.
        write_mem(0, 255);
        write_mem(1, 255);
        start_compute(1'b0, 1'b0, 0, 0);
        read_stream(1'b0, 1'b0, 1'b0, 8);

        // Odd pair, with the c0 write on the start edge.
        write_mem(1, 0);
        start_compute(1'b0, 1'b1, 0, 3);
        write_mem(0, 2);
        check_val("done_after_write", done, 1);
        check_val("err_sticky", err, exp_err);
        // Recompute from DONE; the accepted start clears err.
        start_compute(1'b0, 1'b0, 0, 0);
        read_stream(1'b0, 1'b0, 1'b0, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
